// File: rtl/topk4_sort_ctrl.sv
// rtl/topk4_sort_ctrl.sv - streaming top-4 smallest key selector over a frame of key pairs
// Keeps four ascending result registers and merges one (lo, hi) pair per accepted beat.
module topk4_sort_ctrl #(
  parameter int DATA_W = 10,
  parameter int LEN_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data_a,
  input  logic [DATA_W-1:0] i_data_b,
  output logic              o_ready,
  output logic              o_busy,
  output logic              o_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_data_0,
  output logic [DATA_W-1:0] o_data_1,
  output logic [DATA_W-1:0] o_data_2,
  output logic [DATA_W-1:0] o_data_3
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  localparam logic [DATA_W-1:0] ALL_ONES = '1;

  state_t                   state_q, state_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [LEN_W-1:0]         cnt_q, cnt_d;
  logic [3:0][DATA_W-1:0]   res_q, res_d;
  logic [3:0][DATA_W-1:0]   merged;
  logic [3:0][DATA_W-1:0]   after_lo;
  logic [DATA_W-1:0]        key_lo, key_hi;
  logic                     accept;

  // Insert one key into a sorted list of four, dropping the largest of the five.
  // Strict less-than puts a new key after any equal resident entry.
  function automatic logic [3:0][DATA_W-1:0] insert_key(
    input logic [3:0][DATA_W-1:0] r,
    input logic [DATA_W-1:0]      k
  );
    logic [3:0][DATA_W-1:0] ins;
    ins[0] = (k < r[0]) ? k : r[0];
    for (int i = 1; i < 4; i++) begin
      if (k < r[i]) begin
        ins[i] = (k < r[i-1]) ? r[i-1] : k;
      end else begin
        ins[i] = r[i];
      end
    end
    return ins;
  endfunction

  // Inserting lo then hi is exact: whatever lo displaces can only be outranked by hi.
  always_comb begin
    key_lo   = (i_data_b < i_data_a) ? i_data_b : i_data_a;
    key_hi   = (i_data_b < i_data_a) ? i_data_a : i_data_b;
    after_lo = insert_key(res_q, key_lo);
    merged   = insert_key(after_lo, key_hi);
  end

  assign accept = (state_q == S_LOAD) && i_valid;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          len_d   = i_len;
          cnt_d   = '0;
          res_d   = {4{ALL_ONES}};
          state_d = (i_len != '0) ? S_LOAD : S_DONE;
        end
      end
      S_LOAD: begin
        if (accept) begin
          res_d = merged;
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_d == len_q) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (i_out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      res_q   <= {4{ALL_ONES}};
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign o_ready  = (state_q == S_LOAD);
  assign o_valid  = (state_q == S_DONE);
  assign o_busy   = (state_q != S_IDLE);
  assign o_data_0 = res_q[0];
  assign o_data_1 = res_q[1];
  assign o_data_2 = res_q[2];
  assign o_data_3 = res_q[3];

endmodule

// File: tb/tb_topk4_sort_ctrl.sv
// tb/tb_topk4_sort_ctrl.sv - table-driven bench for topk4_sort_ctrl
module tb_topk4_sort_ctrl;

  localparam int DW = 10;
  localparam int LW = 8;

  typedef struct {
    int len;
    int a[4];
    int b[4];
    int e[4];
    int gap;
  } vec_t;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_start;
  logic [LW-1:0] i_len;
  logic          i_valid;
  logic [DW-1:0] i_data_a;
  logic [DW-1:0] i_data_b;
  logic          o_ready;
  logic          o_busy;
  logic          o_valid;
  logic          i_out_ready;
  logic [DW-1:0] o_data_0, o_data_1, o_data_2, o_data_3;
  logic [DW-1:0] dout [4];

  int errors = 0;
  int checks = 0;
  vec_t vecs [6];

  topk4_sort_ctrl #(.DATA_W(DW), .LEN_W(LW)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_len       (i_len),
    .i_valid     (i_valid),
    .i_data_a    (i_data_a),
    .i_data_b    (i_data_b),
    .o_ready     (o_ready),
    .o_busy      (o_busy),
    .o_valid     (o_valid),
    .i_out_ready (i_out_ready),
    .o_data_0    (o_data_0),
    .o_data_1    (o_data_1),
    .o_data_2    (o_data_2),
    .o_data_3    (o_data_3)
  );

  always #5 i_clk = ~i_clk;

  assign dout[0] = o_data_0;
  assign dout[1] = o_data_1;
  assign dout[2] = o_data_2;
  assign dout[3] = o_data_3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_data(input string tag, input int e0, input int e1, input int e2, input int e3);
    chk({tag, " d0"}, 32'(dout[0]), e0);
    chk({tag, " d1"}, 32'(dout[1]), e1);
    chk({tag, " d2"}, 32'(dout[2]), e2);
    chk({tag, " d3"}, 32'(dout[3]), e3);
  endtask

  function automatic vec_t mk(input int len,
                              input int a0, input int b0, input int a1, input int b1,
                              input int a2, input int b2, input int a3, input int b3,
                              input int e0, input int e1, input int e2, input int e3,
                              input int gap);
    vec_t v;
    v.len = len;
    v.a[0] = a0; v.b[0] = b0; v.a[1] = a1; v.b[1] = b1;
    v.a[2] = a2; v.b[2] = b2; v.a[3] = a3; v.b[3] = b3;
    v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3;
    v.gap = gap;
    return v;
  endfunction

  // Drives a whole frame from IDLE; leaves the block in DONE when handshake is 0.
  task automatic run_frame(input string tag, input vec_t v, input bit handshake);
    chk({tag, " idle busy"}, 32'(o_busy), 0);
    chk({tag, " idle ready"}, 32'(o_ready), 0);
    i_start = 1'b1;
    i_len   = LW'(v.len);
    step();
    i_start = 1'b0;
    for (int p = 0; p < v.len; p++) begin
      for (int g = 0; g < v.gap; g++) begin
        chk({tag, " stall ready"}, 32'(o_ready), 1);
        step();
      end
      chk({tag, " load ready"}, 32'(o_ready), 1);
      chk({tag, " load valid"}, 32'(o_valid), 0);
      i_valid  = 1'b1;
      i_data_a = DW'(v.a[p]);
      i_data_b = DW'(v.b[p]);
      step();
      i_valid  = 1'b0;
    end
    chk({tag, " done valid"}, 32'(o_valid), 1);
    chk({tag, " done ready"}, 32'(o_ready), 0);
    chk({tag, " done busy"}, 32'(o_busy), 1);
    chk_data(tag, v.e[0], v.e[1], v.e[2], v.e[3]);
    if (handshake) begin
      i_out_ready = 1'b1;
      step();
      i_out_ready = 1'b0;
      chk({tag, " post valid"}, 32'(o_valid), 0);
      chk({tag, " post busy"}, 32'(o_busy), 0);
    end
  endtask

  initial begin
    vecs[0] = mk(2, 5, 3, 9, 1, 0, 0, 0, 0, 1, 3, 5, 9, 0);
    vecs[1] = mk(3, 7, 7, 2, 900, 7, 0, 0, 0, 0, 2, 7, 7, 2);
    vecs[2] = mk(1, 4, 8, 0, 0, 0, 0, 0, 0, 4, 8, 1023, 1023, 0);
    vecs[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1023, 1023, 1023, 1023, 0);
    vecs[4] = mk(4, 10, 20, 5, 30, 1, 1, 1000, 2, 1, 1, 2, 5, 1);
    vecs[5] = mk(4, 1, 0, 3, 2, 600, 500, 1023, 1023, 0, 1, 2, 3, 0);

    i_rst_n     = 1'b0;
    i_start     = 1'b0;
    i_len       = '0;
    i_valid     = 1'b0;
    i_data_a    = '0;
    i_data_b    = '0;
    i_out_ready = 1'b0;
    step();
    step();
    chk("reset ready", 32'(o_ready), 0);
    chk("reset valid", 32'(o_valid), 0);
    chk("reset busy", 32'(o_busy), 0);
    chk_data("reset", 1023, 1023, 1023, 1023);
    i_rst_n = 1'b1;
    step();

    for (int k = 0; k < 6; k++) begin
      run_frame($sformatf("vec%0d", k), vecs[k], 1'b1);
      step();
    end

    // Held in DONE: data stable, start ignored, including at the handshake edge.
    run_frame("hold", vecs[0], 1'b0);
    for (int c = 0; c < 5; c++) begin
      i_start = (c == 2);
      i_len   = LW'(1);
      step();
      i_start = 1'b0;
      chk($sformatf("hold%0d valid", c), 32'(o_valid), 1);
      chk($sformatf("hold%0d ready", c), 32'(o_ready), 0);
      chk_data($sformatf("hold%0d", c), 1, 3, 5, 9);
    end
    i_out_ready = 1'b1;
    i_start     = 1'b1;
    step();
    i_out_ready = 1'b0;
    i_start     = 1'b0;
    chk("hs valid", 32'(o_valid), 0);
    chk("hs busy", 32'(o_busy), 0);
    step();
    chk("hs start ignored", 32'(o_busy), 0);

    // Reset mid-frame after two of four pairs.
    i_start = 1'b1;
    i_len   = LW'(4);
    step();
    i_start = 1'b0;
    for (int p = 0; p < 2; p++) begin
      i_valid  = 1'b1;
      i_data_a = DW'(10 + 2 * p);
      i_data_b = DW'(11 + 2 * p);
      step();
    end
    i_valid = 1'b0;
    chk_data("mid", 10, 11, 12, 13);
    chk("mid ready", 32'(o_ready), 1);
    i_rst_n = 1'b0;
    #1;
    chk("rst ready", 32'(o_ready), 0);
    chk("rst busy", 32'(o_busy), 0);
    chk("rst valid", 32'(o_valid), 0);
    chk_data("rst", 1023, 1023, 1023, 1023);
    step();
    i_rst_n = 1'b1;
    run_frame("after_rst", mk(2, 6, 5, 4, 3, 0, 0, 0, 0, 3, 4, 5, 6, 0), 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
